// File: rtl/apb_mem_arbiter_pkg.sv
// Shared definitions for the APB memory arbiter: FSM states, grant IDs, defaults.
package apb_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    AS_IDLE   = 2'd0,
    AS_SETUP  = 2'd1,
    AS_ACCESS = 2'd2,
    AS_RESP   = 2'd3
  } apb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/apb_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered last-grant history.
module rr_arb2
  import apb_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if_i,
  input  logic req_d_i,
  input  logic upd_i,
  input  gnt_e upd_gnt_i,
  output gnt_e gnt_o
);

  gnt_e last_q;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt_o = GNT_IF;
    if (req_if_i && req_d_i) begin
      gnt_o = (last_q == GNT_IF) ? GNT_D : GNT_IF;
    end else if (req_d_i) begin
      gnt_o = GNT_D;
    end
  end

  // Remember the winner once its transfer has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_IF;
    end else if (upd_i) begin
      last_q <= upd_gnt_i;
    end
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one APB master between the fetch and load/store paths, with round-robin
// arbitration, SETUP/ACCESS sequencing and a watchdog for stalled slaves.
module apb_mem_arbiter
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  apb_state_e          state_q, state_d;
  gnt_e                gnt_q, arb_gnt;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W/8-1:0] pstrb_q;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                if_err_q, d_err_q;
  logic                start_xfer;
  logic                timeout_hit;
  logic                xfer_done;

  assign start_xfer  = (state_q == AS_IDLE) && (if_req || d_req);
  // pready has priority: a timeout only counts in a cycle without pready.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == AS_ACCESS) && !pready &&
                       (wd_q == WD_W'(TIMEOUT - 1));
  assign xfer_done   = (state_q == AS_ACCESS) && (pready || timeout_hit);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if_i  (if_req),
    .req_d_i   (d_req),
    .upd_i     (state_q == AS_RESP),
    .upd_gnt_i (gnt_q),
    .gnt_o     (arb_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AS_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and watchdog next value.
  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    case (state_q)
      AS_IDLE:   if (start_xfer) state_d = AS_SETUP;
      AS_SETUP:  state_d = AS_ACCESS;
      AS_ACCESS: begin
        if (xfer_done) begin
          state_d = AS_RESP;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      AS_RESP:   state_d = AS_IDLE;
      default:   state_d = AS_IDLE;
    endcase
  end

  // Phase and completion outputs decoded from the state, so reset drops them at once.
  always_comb begin
    psel     = 1'b0;
    penable  = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      AS_SETUP:  psel = 1'b1;
      AS_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      AS_RESP: begin
        if_ready = (gnt_q == GNT_IF);
        d_ready  = (gnt_q == GNT_D);
      end
      default: ;
    endcase
  end

  // Request latching in IDLE and response capture at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= GNT_IF;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      if (start_xfer) begin
        gnt_q <= arb_gnt;
        if (arb_gnt == GNT_D) begin
          paddr_q  <= d_addr;
          pwrite_q <= d_we;
          pwdata_q <= d_wdata;
          pstrb_q  <= d_wstrb;
        end else begin
          paddr_q  <= if_addr;
          pwrite_q <= 1'b0;
          pwdata_q <= '0;
          pstrb_q  <= '0;
        end
      end
      if (xfer_done) begin
        if (gnt_q == GNT_IF) begin
          if_err_q   <= pready ? pslverr : 1'b1;
          if_rdata_q <= pready ? prdata : '0;
        end else begin
          d_err_q <= pready ? pslverr : 1'b1;
          if (!pready) begin
            d_rdata_q <= '0;
          end else if (!pwrite_q) begin
            d_rdata_q <= prdata;
          end
        end
      end
    end
  end

  assign paddr    = paddr_q;
  assign pwrite   = pwrite_q;
  assign pwdata   = pwdata_q;
  assign pstrb    = pstrb_q;
  assign if_rdata = if_rdata_q;
  assign if_err   = if_err_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Self-checking bench for apb_mem_arbiter (TIMEOUT overridden to 4).
module tb_apb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        if_ready, if_err, d_ready, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: held response values per port and who won last (0 fetch, 1 data).
  logic [31:0] m_if_rdata, m_d_rdata;
  logic        m_if_err, m_d_err;
  bit          m_last;

  typedef struct {
    bit          ifr;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rd;
    bit          slv;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_if_rdata = '0; m_d_rdata = '0;
    m_if_err   = 1'b0; m_d_err = 1'b0;
    m_last     = 1'b0;
  endtask

  // Runs one transfer from an IDLE negedge with requests already driven.
  task automatic do_xfer(input bit exp_gnt, input logic [31:0] exp_addr, input bit exp_we,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                         input int waits, input logic [31:0] rd, input bit slv,
                         input logic [31:0] exp_rdata, input bit exp_err,
                         input bit drop, input string tag);
    int cyc = 0;
    int acc = 0;
    int acc_exp;
    bit stable = 1'b1;
    bit got = 1'b0;
    acc_exp = (waits < int'(TO)) ? waits + 1 : int'(TO);
    while (!got && cyc < 8) begin
      @(negedge clk); cyc++;
      if (psel) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " setup_seen"}, 0, 1);
      return;
    end
    chk({tag, " setup_penable"}, penable, 0);
    chk({tag, " paddr"}, paddr, exp_addr);
    chk({tag, " pwrite"}, pwrite, exp_we);
    if (pwdata !== exp_wdata || pstrb !== exp_strb) stable = 1'b0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk); cyc++;
      if (if_ready || d_ready) begin
        got = 1'b1;
      end else if (penable) begin
        acc++;
        if (pwdata !== exp_wdata || pstrb !== exp_strb || paddr !== exp_addr) stable = 1'b0;
        pready  = (acc > waits);
        prdata  = rd;
        pslverr = slv;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    if (!got) begin
      chk({tag, " ready_seen"}, 0, 1);
      return;
    end
    chk({tag, " port"}, {if_ready, d_ready}, exp_gnt ? 2'b01 : 2'b10);
    chk({tag, " resp_psel"}, {psel, penable}, 2'b00);
    chk({tag, " latency"}, cyc, 2 + acc_exp);
    chk({tag, " access_cycles"}, acc, acc_exp);
    chk({tag, " apb_stable"}, stable, 1);
    if (exp_gnt) begin
      chk({tag, " d_rdata"}, d_rdata, exp_rdata);
      chk({tag, " d_err"}, d_err, exp_err);
      chk({tag, " if_untouched"}, {if_rdata, if_err}, {m_if_rdata, m_if_err});
      m_d_rdata = exp_rdata; m_d_err = exp_err;
      if (drop) d_req = 1'b0;
    end else begin
      chk({tag, " if_rdata"}, if_rdata, exp_rdata);
      chk({tag, " if_err"}, if_err, exp_err);
      chk({tag, " d_untouched"}, {d_rdata, d_err}, {m_d_rdata, m_d_err});
      m_if_rdata = exp_rdata; m_if_err = exp_err;
      if (drop) if_req = 1'b0;
    end
    m_last = exp_gnt;
    @(negedge clk);
    chk({tag, " one_cycle"}, {if_ready, d_ready, psel}, 3'b000);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    bit          g, wexp, seen;
    logic [31:0] er;
    bit          ee;
    int          w;
    logic [31:0] rd;
    bit          slv;

    // Expected results derived from the held-value rules and timeout=4.
    //          ifr we addr          wdata         strb   waits rd            slv exp_rdata     err
    vecs[0] = '{1, 0, 32'h100,  32'h0,        4'h0,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[1] = '{0, 1, 32'h2004, 32'h12345678, 4'b0011, 2, 32'h99999999, 0, 32'h0000D003, 0};
    vecs[2] = '{1, 0, 32'h300,  32'h0,        4'h0,  1, 32'hCAFE0001, 1, 32'hCAFE0001, 1};
    vecs[3] = '{1, 0, 32'h304,  32'h0,        4'h0,  0, 32'h11112222, 0, 32'h11112222, 0};
    vecs[4] = '{0, 0, 32'h400,  32'hAAAA0000, 4'hF,  9, 32'h55555555, 0, 32'h00000000, 1};
    vecs[5] = '{0, 0, 32'h404,  32'hBBBB0000, 4'h1,  3, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0};
    vecs[6] = '{0, 1, 32'h408,  32'hCCCC0000, 4'hC,  3, 32'h77777777, 1, 32'hA5A5A5A5, 1};
    vecs[7] = '{0, 1, 32'h40C,  32'hDDDD0000, 4'h8,  5, 32'h66666666, 0, 32'h00000000, 1};
    vecs[8] = '{1, 0, 32'h500,  32'h0,        4'h0,  2, 32'h01020304, 0, 32'h01020304, 0};

    rst_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    prdata = '0; pready = 0; pslverr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, '0);
    chk("reset_ready", {if_ready, d_ready, if_err, d_err}, 4'b0000);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held from reset: data wins first tie, then alternate.
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = '0; d_wstrb = '0;
    do_xfer(1, 32'h40, 0, 32'h0, 4'h0, 0, 32'h0000D001, 0, 32'h0000D001, 0, 0, "tie1");
    do_xfer(0, 32'h80, 0, 32'h0, 4'h0, 0, 32'h0000F002, 0, 32'h0000F002, 0, 0, "tie2");
    do_xfer(1, 32'h40, 0, 32'h0, 4'h0, 0, 32'h0000D003, 0, 32'h0000D003, 0, 1, "tie3");
    if_req = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].ifr) begin
        if_req = 1; if_addr = vecs[i].addr;
        do_xfer(0, vecs[i].addr, 0, 32'h0, 4'h0, vecs[i].waits, vecs[i].rd, vecs[i].slv,
                vecs[i].exp_rdata, vecs[i].exp_err, 1, $sformatf("vec%0d", i));
      end else begin
        d_req = 1; d_we = vecs[i].we; d_addr = vecs[i].addr;
        d_wdata = vecs[i].wdata; d_wstrb = vecs[i].strb;
        do_xfer(1, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].strb, vecs[i].waits,
                vecs[i].rd, vecs[i].slv, vecs[i].exp_rdata, vecs[i].exp_err, 1,
                $sformatf("vec%0d", i));
      end
    end

    // Reset asserted in the middle of ACCESS.
    d_req = 1; d_we = 0; d_addr = 32'h600; d_wdata = '0; d_wstrb = '0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (penable) seen = 1'b1;
    end
    chk("rst_mid_reached_access", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_psel_drop", {psel, penable}, 2'b00);
    d_req = 0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) seen = 1'b1;
    end
    chk("rst_mid_no_ready", seen, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h700;
    do_xfer(0, 32'h700, 0, 32'h0, 4'h0, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 0, 1, "post_rst");

    // Randomized traffic; the losing requester keeps its request up.
    for (int i = 0; i < 40; i++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = {$urandom_range(0, 65535), 2'b00};
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_we = $urandom_range(0, 1);
        d_addr = {$urandom_range(0, 65535), 2'b00};
        d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
      if (!if_req && !d_req) begin
        if_req = 1; if_addr = {$urandom_range(0, 65535), 2'b00};
      end
      g    = (if_req && d_req) ? !m_last : d_req;
      w    = $urandom_range(0, 5);
      rd   = $urandom;
      slv  = ($urandom_range(0, 3) == 0);
      wexp = g && d_we;
      if (w >= int'(TO)) begin
        er = '0; ee = 1'b1;
      end else begin
        er = wexp ? m_d_rdata : rd;
        ee = slv;
      end
      if (g)
        do_xfer(1, d_addr, d_we, d_wdata, d_wstrb, w, rd, slv, er, ee, 1, $sformatf("rnd%0d", i));
      else
        do_xfer(0, if_addr, 0, 32'h0, 4'h0, w, rd, slv, er, ee, 1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_mem_arbiter.md
# apb_mem_arbiter

Shares the single APB master port of the core between two requesters: the instruction-fetch path (read-only) and the load/store data path. It arbitrates round-robin, sequences the APB SETUP/ACCESS phases and returns a one-cycle completion pulse with read data and error to the granted requester. A watchdog counter ends transfers that never see `pready`. It sits between the multi-cycle control FSM's memory handshake (`mem_read_en`/`mem_write_en`/`mem_ready`) and the APB interconnect.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is DATA_W/8
- `TIMEOUT`, 255, max ACCESS cycles without `pready` before forced error; 0 disables the watchdog
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `if_req` in 1 — fetch request, held until `if_ready`
- `if_addr` in ADDR_W — fetch address
- `if_ready` out 1 — one-cycle completion pulse
- `if_rdata` out DATA_W — fetch data, valid with `if_ready`
- `if_err` out 1 — slave error or timeout, valid with `if_ready`
- `d_req` in 1 — data request, held until `d_ready`
- `d_we` in 1 — 1 = write
- `d_addr` in ADDR_W; `d_wdata` in DATA_W; `d_wstrb` in DATA_W/8
- `d_ready` out 1; `d_rdata` out DATA_W; `d_err` out 1 — same semantics as the fetch port
- `psel`, `penable`, `pwrite` out 1; `paddr` out ADDR_W; `pwdata` out DATA_W; `pstrb` out DATA_W/8
- `prdata` in DATA_W; `pready` in 1; `pslverr` in 1

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: with no request, stay. With one request, grant it. With both, grant the port not granted last; `last_grant` resets to fetch, so data wins the first tie. Latch grant, address, we, wdata and strb into APB output registers, then go to SETUP.
- Fetch grant: `pwrite`=0, `pstrb`=0, `pwdata`=0.
- SETUP: `psel`=1, `penable`=0, then unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. On `pready`=1, capture `prdata` (reads only) and `pslverr` into the granted port's rdata/err, then go to RESP. Without `pready`, the watchdog counts; on reaching TIMEOUT, set err=1, set rdata=0 and go to RESP.
- RESP: `psel`=`penable`=0; pulse the granted port's ready for exactly one cycle; update `last_grant`; return to IDLE.
- Requester inputs are sampled only in IDLE. Later changes, including dropping `req`, are ignored and the transfer still completes.
- rdata/err hold their value until the next completion on that port. The other port's outputs are untouched.

## Timing
- Reset (asynchronous, immediate): state IDLE; all APB outputs 0; `if_ready`, `d_ready`, `if_err`, `d_err` = 0; `if_rdata`, `d_rdata` = 0; watchdog = 0; `last_grant` = fetch.
- Reset asserted mid-transfer drops `psel`/`penable` at once. No ready pulse is issued.
- Minimum latency: `req` high in IDLE cycle T; SETUP at T+1; ACCESS at T+2; with `pready` at T+2, the ready pulse appears at T+3. Back-to-back transfers take 4 cycles each.
- Every extra `pready`=0 cycle adds one cycle.
- Timeout: the ready pulse with err=1 comes TIMEOUT ACCESS cycles after the first ACCESS cycle, plus one.
- A requester must drop `req` in the cycle after its ready pulse, or re-issue it. A `req` still high in IDLE is treated as a new request.
- `pready` and timeout reached in the same cycle: `pready` wins and err = `pslverr`.

## Structure
- Shared package/header: state encodings (`AS_IDLE`..`AS_RESP`), grant IDs (`GNT_IF`=0, `GNT_D`=1), default TIMEOUT.
- Optional sub-module `rr_arb2`: 2-input round-robin arbiter, combinational grant plus registered `last_grant` update. Everything else lives in one module.

## Test plan
- Single fetch, `if_addr`=0x100, `prdata`=0xDEADBEEF, `pready` in the first ACCESS cycle -> `paddr`=0x100, `pwrite`=0, `if_ready` pulse 3 cycles after `req`, `if_rdata`=0xDEADBEEF, `if_err`=0.
- Data write, addr 0x2004, wdata 0x12345678, strb 0b0011, 2 wait states -> `pwdata`/`pstrb` stable through SETUP and ACCESS, `penable` high 3 cycles, `d_ready` pulse, `d_err`=0.
- Both requests asserted together from reset, held across completions -> grant order data, fetch, data; no pulse on the non-granted port.
- TIMEOUT=4, `pready` tied 0 -> ACCESS lasts 4 cycles, then `d_ready`=1 with `d_err`=1 and `d_rdata`=0.
- Read with `pslverr`=1 on `pready` -> err=1 and rdata=`prdata`. A later good read clears err to 0.
- `rst_n` low during ACCESS -> `psel`/`penable` drop combinationally, no ready pulse, and a fresh fetch after release completes normally.
